// File: rtl/lat_cmd_decoder.sv
// Driver-side serial command decoder: counts SCLK rises while LAT is high and decodes the count. Optional LAT_DECODER_ERR_CNT_EN.
// Latency: LAT pin fall to result pulse = SYNC_STAGES+2 clk.
// Backpressure: none; the bus is sampled every clk and pulses are never held.
module lat_cmd_decoder #(
  parameter int SR_WIDTH    = 48,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                SCLK,
  input  logic                SIN,
  input  logic                LAT,
  output logic [SR_WIDTH-1:0] fc_reg,
  output logic                fc_valid,
  output logic [SR_WIDTH-1:0] gs_word,
  output logic                gs_word_valid,
  output logic                gs_latch,
  output logic                fcwrten_armed,
  output logic                cmd_err,
  output logic [15:0]         err_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, DECODE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] CMD_FCWRTEN = CNT_W'(15);
  localparam logic [CNT_W-1:0] CMD_WRTFC   = CNT_W'(5);
  localparam logic [CNT_W-1:0] CMD_LATGS   = CNT_W'(3);
  localparam logic [CNT_W-1:0] CMD_WRTGS   = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sclk_q, sin_q, lat_q;
  logic [SYNC_STAGES:0]   gate_q;
  logic                   sclk_d, lat_d;
  logic                   sclk_s, sin_s, lat_s;
  logic                   edge_en, sclk_rise, lat_fall, lat_hi;
  logic [SR_WIDTH-1:0]    sr;
  logic [CNT_W-1:0]       lat_cnt;
  logic                   armed;
  state_t                 state, state_nxt;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign sin_s  = sin_q[SYNC_STAGES-1];
  assign lat_s  = lat_q[SYNC_STAGES-1];

  // History flops track the synced pins during the gate window so a high SCLK never looks like an edge
  assign edge_en   = gate_q[SYNC_STAGES];
  assign sclk_rise = edge_en & sclk_s & ~sclk_d;
  assign lat_fall  = edge_en & ~lat_s & lat_d;
  // An SCLK rise coinciding with the LAT fall still belongs to the command
  assign lat_hi    = lat_s | lat_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      sin_q  <= '0;
      lat_q  <= '0;
      sclk_d <= 1'b0;
      lat_d  <= 1'b0;
      gate_q <= '0;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], SCLK};
      sin_q  <= {sin_q[SYNC_STAGES-2:0], SIN};
      lat_q  <= {lat_q[SYNC_STAGES-2:0], LAT};
      sclk_d <= sclk_s;
      lat_d  <= lat_s;
      gate_q <= {gate_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (sclk_rise) begin
      sr <= {sr[SR_WIDTH-2:0], sin_s};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= '0;
    end else if (state == DECODE) begin
      lat_cnt <= '0;
    end else if (sclk_rise && lat_hi && (lat_cnt != CNT_MAX)) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sclk_rise && lat_hi) state_nxt = lat_fall ? DECODE : COUNT;
      COUNT:   if (lat_fall) state_nxt = DECODE;
      DECODE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_reg        <= '0;
      fc_valid      <= 1'b0;
      gs_word       <= '0;
      gs_word_valid <= 1'b0;
      gs_latch      <= 1'b0;
      cmd_err       <= 1'b0;
      armed         <= 1'b0;
    end else begin
      fc_valid      <= 1'b0;
      gs_word_valid <= 1'b0;
      gs_latch      <= 1'b0;
      cmd_err       <= 1'b0;
      if (state == DECODE) begin
        case (lat_cnt)
          CMD_FCWRTEN: armed <= 1'b1;
          CMD_WRTFC: begin
            // An unarmed WRTFC leaves the arm state and fc_reg untouched
            if (armed) begin
              fc_reg   <= sr;
              fc_valid <= 1'b1;
              armed    <= 1'b0;
            end else begin
              cmd_err  <= 1'b1;
            end
          end
          CMD_LATGS: begin
            gs_word  <= sr;
            gs_latch <= 1'b1;
            armed    <= 1'b0;
          end
          CMD_WRTGS: begin
            gs_word       <= sr;
            gs_word_valid <= 1'b1;
            armed         <= 1'b0;
          end
          default: begin
            cmd_err <= 1'b1;
            armed   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fcwrten_armed = armed;

`ifdef LAT_DECODER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cmd_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lat_cmd_decoder.sv
// Scoreboard bench for lat_cmd_decoder: stimulus pushes expected pulses, a monitor pops and compares.
module tb_lat_cmd_decoder;

  localparam int SR_WIDTH    = 48;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 5;
  localparam int LATENCY     = SYNC_STAGES + 2;

  localparam logic [3:0] P_FC  = 4'b1000;
  localparam logic [3:0] P_GSV = 4'b0100;
  localparam logic [3:0] P_GSL = 4'b0010;
  localparam logic [3:0] P_ERR = 4'b0001;

`ifdef LAT_DECODER_ERR_CNT_EN
  localparam int ERR_EXP = 3;
`else
  localparam int ERR_EXP = 0;
`endif

  logic                clk;
  logic                rst_n;
  logic                SCLK;
  logic                SIN;
  logic                LAT;
  logic [SR_WIDTH-1:0] fc_reg;
  logic                fc_valid;
  logic [SR_WIDTH-1:0] gs_word;
  logic                gs_word_valid;
  logic                gs_latch;
  logic                fcwrten_armed;
  logic                cmd_err;
  logic [15:0]         err_cnt;

  lat_cmd_decoder #(
    .SR_WIDTH   (SR_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SCLK         (SCLK),
    .SIN          (SIN),
    .LAT          (LAT),
    .fc_reg       (fc_reg),
    .fc_valid     (fc_valid),
    .gs_word      (gs_word),
    .gs_word_valid(gs_word_valid),
    .gs_latch     (gs_latch),
    .fcwrten_armed(fcwrten_armed),
    .cmd_err      (cmd_err),
    .err_cnt      (err_cnt)
  );

  typedef struct {
    logic [3:0]          pulses;
    logic [SR_WIDTH-1:0] data;
    logic                armed;
    int                  t_fall;
  } exp_t;

  exp_t                sb[$];
  int                  total = 0;
  int                  bad = 0;
  int                  cyc = 0;
  int                  last_fall = 0;
  logic                armed_m = 1'b0;
  logic [SR_WIDTH-1:0] fc_m = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] p;
    exp_t       e;
    p = {fc_valid, gs_word_valid, gs_latch, cmd_err};
    if (p != 4'b0000) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'(p), 64'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 64'(p), 64'(e.pulses));
        check("latency", 64'(cyc - e.t_fall), 64'(LATENCY));
        check("data", (e.pulses[2] | e.pulses[1]) ? 64'(gs_word) : 64'(fc_reg), 64'(e.data));
        check("armed_after", 64'(fcwrten_armed), 64'(e.armed));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_pulse(input logic d, input logic l);
    SIN = d;
    LAT = l;
    idle(2);
    SCLK = 1'b1;
    idle(4);
    SCLK = 1'b0;
    idle(2);
  endtask

  // Sends bits nbits-1..0 of d MSB first with LAT high on the last nlat of them
  task automatic frame(input logic [SR_WIDTH-1:0] d, input int nbits, input int nlat);
    for (int i = nbits - 1; i >= 0; i--) sclk_pulse(d[i], i < nlat);
    LAT = 1'b0;
    last_fall = cyc;
  endtask

  task automatic push_exp(input logic [3:0] p, input logic [SR_WIDTH-1:0] d);
    exp_t e;
    e.pulses = p;
    e.data   = d;
    e.armed  = armed_m;
    e.t_fall = last_fall;
    sb.push_back(e);
  endtask

  task automatic cmd_fcwrten();
    frame('0, 15, 15);
    armed_m = 1'b1;
    idle(12);
  endtask

  task automatic cmd_wrtfc(input logic [SR_WIDTH-1:0] d);
    frame(d, 48, 5);
    if (armed_m) begin
      fc_m    = d;
      armed_m = 1'b0;
      push_exp(P_FC, d);
    end else begin
      push_exp(P_ERR, fc_m);
    end
    idle(12);
  endtask

  task automatic cmd_gs(input logic [SR_WIDTH-1:0] d, input int nlat);
    frame(d, 48, nlat);
    armed_m = 1'b0;
    push_exp((nlat == 1) ? P_GSV : P_GSL, d);
    idle(12);
  endtask

  task automatic cmd_illegal(input logic [SR_WIDTH-1:0] d, input int nlat);
    frame(d, 48, nlat);
    armed_m = 1'b0;
    push_exp(P_ERR, fc_m);
    idle(12);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fc_reg"}, 64'(fc_reg), 64'd0);
    check({tag, "_gs_word"}, 64'(gs_word), 64'd0);
    check({tag, "_pulses"}, 64'({fc_valid, gs_word_valid, gs_latch, cmd_err}), 64'd0);
    check({tag, "_armed"}, 64'(fcwrten_armed), 64'd0);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
  endtask

  initial begin
    logic [SR_WIDTH-1:0] d;
    rst_n = 1'b0;
    SCLK  = 1'b0;
    SIN   = 1'b0;
    LAT   = 1'b0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(6);

    // FCWRTEN then a full armed WRTFC frame
    cmd_fcwrten();
    check("armed_after_fcwrten", 64'(fcwrten_armed), 64'd1);
    cmd_wrtfc(48'hA5A5_0F0F_1234);

    // WRTFC without arming is an error and leaves fc_reg alone
    cmd_wrtfc(48'hFFFF_0000_FFFF);

    // WRTGS and LATGS
    cmd_gs(48'h0123_4567_89AB, 1);
    cmd_gs(48'hFEDC_BA98_7654, 3);

    // LAT pulse without any SCLK edge must be ignored
    LAT = 1'b1;
    idle(8);
    LAT = 1'b0;
    idle(16);

    // Single SCLK rise arriving together with the LAT fall still counts as one edge
    d = 48'h1357_9BDF_2468;
    for (int i = 47; i >= 1; i--) sclk_pulse(d[i], 1'b0);
    SIN = d[0];
    LAT = 1'b1;
    idle(2);
    SCLK = 1'b1;
    LAT  = 1'b0;
    last_fall = cyc;
    armed_m = 1'b0;
    push_exp(P_GSV, d);
    idle(4);
    SCLK = 1'b0;
    idle(12);

    // Illegal count while armed disarms; the following WRTFC is then an error too
    cmd_fcwrten();
    check("armed_before_illegal", 64'(fcwrten_armed), 64'd1);
    cmd_illegal(48'h0000_1111_2222, 7);
    cmd_wrtfc(48'h3333_4444_5555);

    // Reset in the middle of a WRTFC data frame
    cmd_fcwrten();
    d = 48'hC0DE_CAFE_BEEF;
    for (int i = 47; i >= 28; i--) sclk_pulse(d[i], 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    armed_m = 1'b0;
    fc_m    = '0;
    idle(3);
    rst_n = 1'b1;
    idle(6);
    cmd_fcwrten();
    cmd_wrtfc(48'hA5A5_0F0F_1234);

    // Three illegal commands, including a saturated count
    cmd_illegal(48'h0000_0000_00AA, 2);
    cmd_illegal(48'h0000_0000_00BB, 4);
    cmd_illegal(48'h0000_0000_00CC, 40);

    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    idle(2);
    check("err_cnt_final", 64'(err_cnt), 64'(ERR_EXP));
    check("fc_reg_final", 64'(fc_reg), 64'(48'hA5A5_0F0F_1234));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
